// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single system memory port between the 6502 core and a
//   DMA / test-loader requester. The core is stalled through cpu_rdy while
//   DMA owns the bus. A dead turnaround cycle sits between CPU and DMA
//   ownership. DMA bursts are capped at DMA_BURST grants, and the CPU then
//   gets at least one cycle before DMA can win again.
//
//   Optional build macro: ARB_STATS_EN
//     Adds saturating counters stat_dma_cycles and stat_cpu_stalls.
//     The default build leaves the macro undefined. Arbitration is
//     identical either way.

module mem_bus_arbiter #(
   parameter int AW        = 16,
   parameter int DW        = 8,
   parameter int DMA_BURST = 4    // legal range 1..15 (4-bit burst counter)
) (
   input  logic          ph1,
   input  logic          resetb,

   // CPU side (the core requests every cycle)
   input  logic [AW-1:0] cpu_addr,
   input  logic          cpu_we,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_rdy,
   output logic [DW-1:0] cpu_rdata,

   // DMA / loader side
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic          dma_rvalid,
   output logic [DW-1:0] dma_rdata,

   // Memory port
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]   stat_dma_cycles,
   output logic [15:0]   stat_cpu_stalls
`endif
);

   // Bus ownership. S_TURN is the dead cycle between the CPU and the DMA.
   typedef enum logic [1:0] {
      S_CPU  = 2'd0,
      S_TURN = 2'd1,
      S_DMA  = 2'd2
   } state_t;

   localparam logic [3:0] BURST_LIM = 4'(DMA_BURST);

   state_t        r_state;
   state_t        w_state_next;

   logic [3:0]    r_burst_cnt;
   logic [3:0]    w_burst_inc;
   logic          w_burst_done;

   // Read-return tracking: r_rd_pend marks a read issued last cycle, and
   // r_rd_dma records which side issued it.
   logic          r_rd_pend;
   logic          r_rd_dma;
   logic          w_rd_issue;
   logic          w_cpu_rd_ret;
   logic [DW-1:0] r_cpu_rdata;
   logic [DW-1:0] r_dma_rdata;

   // The current grant is the last one of the burst when the counter would
   // reach the limit. The limit is never above 15, so the counter cannot wrap.
   assign w_burst_inc  = r_burst_cnt + 4'd1;
   assign w_burst_done = (w_burst_inc == BURST_LIM);

   // State register: an asynchronous reset aborts any burst immediately.
   always_ff @(posedge ph1 or negedge resetb) begin
      if (!resetb) begin
         r_state <= S_CPU;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic. S_CPU always lasts at least one cycle, which gives
   // the CPU its guaranteed slot after a burst-limited DMA exit.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_CPU: begin
            if (dma_req) begin
               w_state_next = S_TURN;
            end
         end
         S_TURN: begin
            w_state_next = dma_req ? S_DMA : S_CPU;
         end
         S_DMA: begin
            if (!dma_req || w_burst_done) begin
               w_state_next = S_CPU;
            end
         end
         default: begin
            w_state_next = S_CPU;
         end
      endcase
   end

   // Output logic: grants and memory-port mux are combinational on the state.
   always_comb begin
      cpu_rdy   = 1'b0;
      dma_gnt   = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      case (r_state)
         S_CPU: begin
            cpu_rdy   = 1'b1;
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
         end
         S_DMA: begin
            dma_gnt   = dma_req;
            mem_en    = dma_req;
            mem_we    = dma_req & dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
         end
         default: begin
            // S_TURN: dead cycle. Memory stays idle and nobody is granted.
            mem_en = 1'b0;
            mem_we = 1'b0;
         end
      endcase
   end

   // Burst counter: cleared on entry to S_DMA and advanced on every DMA grant.
   always_ff @(posedge ph1 or negedge resetb) begin
      if (!resetb) begin
         r_burst_cnt <= 4'd0;
      end else if (r_state == S_TURN && w_state_next == S_DMA) begin
         r_burst_cnt <= 4'd0;
      end else if (dma_gnt) begin
         r_burst_cnt <= w_burst_inc;
      end
   end

   assign w_rd_issue = mem_en & ~mem_we;

   // Owner bit for the read in flight. Memory returns data one cycle later.
   always_ff @(posedge ph1 or negedge resetb) begin
      if (!resetb) begin
         r_rd_pend <= 1'b0;
         r_rd_dma  <= 1'b0;
      end else begin
         r_rd_pend <= w_rd_issue;
         r_rd_dma  <= (r_state == S_DMA);
      end
   end

   assign w_cpu_rd_ret = r_rd_pend & ~r_rd_dma;
   assign dma_rvalid   = r_rd_pend &  r_rd_dma;

   // Hold the last returned read data for each side. The CPU's data stays
   // stable while it is stalled.
   always_ff @(posedge ph1 or negedge resetb) begin
      if (!resetb) begin
         r_cpu_rdata <= '0;
         r_dma_rdata <= '0;
      end else begin
         if (w_cpu_rd_ret) begin
            r_cpu_rdata <= mem_rdata;
         end
         if (dma_rvalid) begin
            r_dma_rdata <= mem_rdata;
         end
      end
   end

   // Returned data is live in the return cycle and held afterwards.
   assign cpu_rdata = w_cpu_rd_ret ? mem_rdata : r_cpu_rdata;
   assign dma_rdata = dma_rvalid   ? mem_rdata : r_dma_rdata;

`ifdef ARB_STATS_EN
   logic [15:0] r_stat_dma_cycles;
   logic [15:0] r_stat_cpu_stalls;

   // Saturating activity counters: DMA grant cycles and CPU stall cycles
   // (the turnaround cycle counts as a stall).
   always_ff @(posedge ph1 or negedge resetb) begin
      if (!resetb) begin
         r_stat_dma_cycles <= 16'h0000;
         r_stat_cpu_stalls <= 16'h0000;
      end else begin
         if (dma_gnt && r_stat_dma_cycles != 16'hFFFF) begin
            r_stat_dma_cycles <= r_stat_dma_cycles + 16'd1;
         end
         if (!cpu_rdy && r_stat_cpu_stalls != 16'hFFFF) begin
            r_stat_cpu_stalls <= r_stat_cpu_stalls + 16'd1;
         end
      end
   end

   assign stat_dma_cycles = r_stat_dma_cycles;
   assign stat_cpu_stalls = r_stat_cpu_stalls;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter. A behavioural memory sits on the mem
//   port: ROM-like default contents (FFFC reads 00) plus any written bytes.
//   Inputs change just after the falling edge. Outputs are sampled 1 ns later,
//   well away from the rising edge.

module tb_mem_bus_arbiter;

   logic        ph1 = 1'b0;
   logic        resetb;
   logic [15:0] cpu_addr;
   logic        cpu_we;
   logic [7:0]  cpu_wdata;
   logic        cpu_rdy;
   logic [7:0]  cpu_rdata;
   logic        dma_req;
   logic        dma_we;
   logic [15:0] dma_addr;
   logic [7:0]  dma_wdata;
   logic        dma_gnt;
   logic        dma_rvalid;
   logic [7:0]  dma_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
`ifdef ARB_STATS_EN
   logic [15:0] stat_dma_cycles;
   logic [15:0] stat_cpu_stalls;
`endif

   int n_checks = 0;
   int n_errors = 0;

   mem_bus_arbiter #(.AW(16), .DW(8), .DMA_BURST(4)) dut (
      .ph1        (ph1),
      .resetb     (resetb),
      .cpu_addr   (cpu_addr),
      .cpu_we     (cpu_we),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdy    (cpu_rdy),
      .cpu_rdata  (cpu_rdata),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_gnt    (dma_gnt),
      .dma_rvalid (dma_rvalid),
      .dma_rdata  (dma_rdata),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
`ifdef ARB_STATS_EN
      ,
      .stat_dma_cycles (stat_dma_cycles),
      .stat_cpu_stalls (stat_cpu_stalls)
`endif
   );

   always #5 ph1 = ~ph1;

   // Memory model: unwritten locations return a fixed pattern, FFFC is 00.
   logic [7:0] ram     [0:65535];
   bit         wr_flag [0:65535];

   function automatic logic [7:0] rom_val(input logic [15:0] a);
      return (a == 16'hFFFC) ? 8'h00 : (a[7:0] ^ 8'h3C);
   endfunction

   always @(posedge ph1) begin
      if (mem_en) begin
         if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            wr_flag[mem_addr] <= 1'b1;
         end else begin
            mem_rdata <= wr_flag[mem_addr] ? ram[mem_addr] : rom_val(mem_addr);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(negedge ph1);
   endtask

   // Bus class seen in a cycle: 0 CPU grant, 1 idle/turn, 2 DMA grant, 3 other
   function automatic int classify();
      if (cpu_rdy) return 0;
      if (dma_gnt) return 2;
      if (mem_en)  return 3;
      return 1;
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int grants, max_run, run, rv_seen, cls;
      int exp_cls [18] = '{0,1,2,2,2,2,0,1,2,2,2,2,0,1,2,2,1,0};

      resetb    = 1'b0;
      cpu_addr  = 16'h0000;
      cpu_we    = 1'b0;
      cpu_wdata = 8'h00;
      dma_req   = 1'b0;
      dma_we    = 1'b0;
      dma_addr  = 16'h0000;
      dma_wdata = 8'h00;

      // Reset state
      next_cyc(); next_cyc(); #1;
      chk("rst_cpu_rdy",   cpu_rdy, 1);
      chk("rst_dma_gnt",   dma_gnt, 0);
      chk("rst_rvalid",    dma_rvalid, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_dma_rdata", dma_rdata, 0);
      chk("rst_mem_we",    mem_we, 0);
      chk("rst_burst_cnt", dut.r_burst_cnt, 0);

      // CPU writes AA to 00A9 with no DMA traffic
      next_cyc();
      resetb = 1'b1; cpu_addr = 16'h00A9; cpu_we = 1'b1; cpu_wdata = 8'hAA;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("cw%0d_rdy", i),   cpu_rdy, 1);
         chk($sformatf("cw%0d_we", i),    mem_we, 1);
         chk($sformatf("cw%0d_addr", i),  mem_addr, 16'h00A9);
         chk($sformatf("cw%0d_wdata", i), mem_wdata, 8'hAA);
         next_cyc();
      end
      cpu_we = 1'b0; #1;
      chk("cr_mem_en", mem_en, 1);
      chk("ram_a9", ram[16'h00A9], 8'hAA);
      next_cyc(); #1;
      chk("cr_rdata", cpu_rdata, 8'hAA);

      // Single DMA read of FFFC while the CPU keeps reading 00A9
      next_cyc();
      dma_req = 1'b1; dma_addr = 16'hFFFC; dma_we = 1'b0; #1;
      chk("s1_c0_rdy", cpu_rdy, 1);
      chk("s1_c0_addr", mem_addr, 16'h00A9);
      chk("s1_c0_gnt", dma_gnt, 0);
      next_cyc(); #1;
      chk("s1_turn_rdy", cpu_rdy, 0);
      chk("s1_turn_en", mem_en, 0);
      chk("s1_turn_gnt", dma_gnt, 0);
      chk("s1_turn_cpu_rdata", cpu_rdata, 8'hAA);
      next_cyc(); #1;
      chk("s1_dma_gnt", dma_gnt, 1);
      chk("s1_dma_en", mem_en, 1);
      chk("s1_dma_addr", mem_addr, 16'hFFFC);
      next_cyc();
      dma_req = 1'b0; #1;
      chk("s1_rvalid", dma_rvalid, 1);
      chk("s1_rdata", dma_rdata, 8'h00);
      chk("s1_rv_rdy", cpu_rdy, 0);
      chk("s1_hold_cpu_rdata", cpu_rdata, 8'hAA);
      next_cyc(); #1;
      chk("s1_back_rdy", cpu_rdy, 1);
      chk("s1_back_rvalid", dma_rvalid, 0);

      // One-cycle dma_req pulse: turnaround only, no grant, memory idle
      next_cyc();
      dma_req = 1'b1; cpu_addr = 16'h0300; cpu_we = 1'b1; cpu_wdata = 8'h55; #1;
      chk("p_c0_we", mem_we, 1);
      next_cyc();
      dma_req = 1'b0; #1;
      chk("p_turn_rdy", cpu_rdy, 0);
      chk("p_turn_en", mem_en, 0);
      chk("p_turn_we", mem_we, 0);
      chk("p_turn_gnt", dma_gnt, 0);
      next_cyc(); #1;
      chk("p_back_rdy", cpu_rdy, 1);
      chk("p_back_gnt", dma_gnt, 0);
      chk("p_back_we", mem_we, 1);

      // Fresh reset so the statistics start from zero for the burst run
      next_cyc();
      resetb = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h00A9;
      next_cyc();
      resetb = 1'b1;

      // DMA writes ten bytes (0200+k <= 80+k) with dma_req held until done
      next_cyc();
      grants = 0; max_run = 0; run = 0; rv_seen = 0;
      dma_req = 1'b1; dma_we = 1'b1;
      for (int k = 0; k < 18; k++) begin
         if (k > 0) next_cyc();
         if (grants == 10) dma_req = 1'b0;
         dma_addr  = 16'h0200 + 16'(grants);
         dma_wdata = 8'h80 + 8'(grants);
         #1;
         cls = classify();
         chk($sformatf("burst_c%0d", k), cls, exp_cls[k]);
         if (dma_rvalid) rv_seen++;
         if (!cpu_rdy) begin
            run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
         if (dma_gnt) grants++;
`ifdef ARB_STATS_EN
         // First cycle after the tenth grant: counters cover exactly the burst
         if (k == 16) begin
            chk("stat_dma_10", stat_dma_cycles, 16'd10);
            chk("stat_stall_13", stat_cpu_stalls, 16'd13);
         end
`endif
      end
      chk("burst_grants", grants, 10);
      chk("burst_max_stall", max_run, 5);
      chk("burst_no_rvalid", rv_seen, 0);

      // CPU reads back a DMA-written byte
      next_cyc();
      cpu_addr = 16'h0209; #1;
      next_cyc(); #1;
      chk("rb_0209", cpu_rdata, 8'h89);

`ifdef ARB_STATS_EN
      // Saturation: preload both counters just below the top
      next_cyc();
      force dut.r_stat_dma_cycles = 16'hFFFE;
      force dut.r_stat_cpu_stalls = 16'hFFFE;
      #1;
      release dut.r_stat_dma_cycles;
      release dut.r_stat_cpu_stalls;
      grants = 0;
      dma_we = 1'b0; dma_addr = 16'h0201;
      for (int k = 0; k < 12; k++) begin
         next_cyc();
         dma_req = (grants < 3);
         #1;
         if (dma_gnt) grants++;
      end
      chk("sat_grants", grants, 3);
      chk("sat_dma", stat_dma_cycles, 16'hFFFF);
      chk("sat_stall", stat_cpu_stalls, 16'hFFFF);
`endif

      // Reset on the second DMA cycle of a read burst
      next_cyc();
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0203; #1;
      chk("ra_c0_rdy", cpu_rdy, 1);
      next_cyc(); #1;
      chk("ra_turn_en", mem_en, 0);
      next_cyc(); #1;
      chk("ra_d1_gnt", dma_gnt, 1);
      next_cyc(); #1;
      chk("ra_d2_gnt", dma_gnt, 1);
      chk("ra_d2_rvalid", dma_rvalid, 1);
      chk("ra_d2_rdata", dma_rdata, 8'h83);
      chk("ra_d2_cnt", dut.r_burst_cnt, 1);
      resetb = 1'b0; #1;
      chk("ra_rst_rdy", cpu_rdy, 1);
      chk("ra_rst_rvalid", dma_rvalid, 0);
      chk("ra_rst_gnt", dma_gnt, 0);
      chk("ra_rst_cnt", dut.r_burst_cnt, 0);
      chk("ra_rst_state", dut.r_state, 0);
      chk("ra_rst_dma_rdata", dma_rdata, 0);
      dma_req = 1'b0;
      next_cyc();
      resetb = 1'b1;
      next_cyc(); #1;
      chk("ra_after_rdy", cpu_rdy, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single system memory port (ROM/RAM behind top.mem) between the 6502 core and a DMA/test-loader requester.
- Sits between the core's address/data bus and mem.
- Stalls the core via cpu_rdy while DMA owns the bus.
- Lets benches and loaders preload or inspect RAM while the core runs, without racing the core's accesses.

Parameters:
- AW, 16, address width.
- DW, 8, data width.
- DMA_BURST, 4, maximum consecutive DMA grant cycles before the CPU is guaranteed one grant (range 1..15).

Ports:
- ph1  in  1  clock; all state updates on rising edge.
- resetb  in  1  asynchronous active-low reset.
- cpu_addr  in  AW  CPU address.
- cpu_we  in  1  CPU write strobe.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdy  out  1  CPU access accepted this cycle; low = core must hold its bus.
- cpu_rdata  out  DW  read data returned to CPU.
- dma_req  in  1  DMA requests one access this cycle.
- dma_we  in  1  DMA write strobe.
- dma_addr  in  AW  DMA address.
- dma_wdata  in  DW  DMA write data.
- dma_gnt  out  1  DMA access accepted this cycle.
- dma_rvalid  out  1  dma_rdata valid (read issued the previous cycle).
- dma_rdata  out  DW  read data returned to DMA.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid one cycle after a read with mem_en=1.

Behaviour:
- The CPU requests every cycle; there is no cpu_req.
- States:
  - S_CPU (reset state).
  - S_DMA.
  - S_TURN: one dead cycle, mem_en=0, neither side granted.
- Transitions:
  - S_CPU -> S_TURN when dma_req=1; the current cycle remains a CPU grant.
  - S_TURN -> S_DMA when dma_req=1; S_TURN -> S_CPU when dma_req=0 (request withdrawn).
  - S_DMA -> S_CPU when dma_req=0, or when burst_cnt reaches DMA_BURST. The DMA access in that last cycle still completes.
- Fairness: after a burst-limited exit, S_CPU holds for at least one cycle even if dma_req=1, then re-arbitrates.
- Burst counter: burst_cnt is 4 bits. It clears on S_DMA entry and increments per DMA grant. Comparison is equality with DMA_BURST; no wrap is possible.
- Combinational grants:
  - cpu_rdy=1 only in S_CPU.
  - dma_gnt=1 only in S_DMA with dma_req=1.
- Memory mux:
  - In S_CPU: mem_en=1, CPU address, write strobe and write data pass through.
  - In S_DMA: mem_en=dma_req, DMA address, write strobe and write data pass through.
  - In S_TURN: mem_en=0 and mem_we=0.
- Read return:
  - A registered owner bit captures who issued each read.
  - The cycle after a CPU read, cpu_rdata=mem_rdata.
  - The cycle after a DMA read, dma_rvalid=1 and dma_rdata=mem_rdata.
  - Writes never assert dma_rvalid.
- cpu_rdata holds its last value while the CPU is stalled, so the core's data latch is stable.
- Reset values:
  - state=S_CPU, burst_cnt=0, dma_rvalid=0.
  - cpu_rdata=0, dma_rdata=0.
  - cpu_rdy=1 (reset state); mem_we=0.
- Reset asserted mid-DMA aborts the burst immediately. Any pending dma_rvalid is dropped.
- dma_req deasserting in S_TURN costs one dead cycle; no grant is issued.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined, adds outputs stat_dma_cycles[15:0] and stat_cpu_stalls[15:0].
  - stat_dma_cycles increments per dma_gnt cycle.
  - stat_cpu_stalls increments per cycle with cpu_rdy=0, S_TURN included.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, the outputs and counters do not exist; arbitration behaviour is identical.

Test Plan:
- Reset, no DMA: cpu_addr=16'h00A9, cpu_we=1, cpu_wdata=8'hAA.
  -> cpu_rdy=1 every cycle; mem_we=1 with mem_addr=16'h00A9 in the same cycle; RAM[169]=8'hAA.
- Single DMA read of 16'hFFFC (ROM 8'h00) while the CPU runs.
  -> one S_TURN cycle (mem_en=0, cpu_rdy=0), then dma_gnt=1.
  -> next cycle dma_rvalid=1, dma_rdata=8'h00; the following cycle cpu_rdy=1.
- dma_req held high for 10 cycles, DMA_BURST=4.
  -> grants follow the pattern TURN, 4xDMA, CPU, TURN, 4xDMA, CPU, TURN, 2xDMA.
  -> exactly 10 dma_gnt pulses; cpu_rdy is never low for more than 5 consecutive cycles.
- dma_req pulses for one cycle then drops.
  -> one S_TURN, back to S_CPU, no dma_gnt, no memory enable during the dead cycle.
- resetb pulled low on the 2nd DMA cycle of a burst.
  -> immediately state=S_CPU, dma_rvalid=0, cpu_rdy=1, burst_cnt=0.
- With ARB_STATS_EN defined, run the 10-cycle burst scenario.
  -> stat_dma_cycles=10, stat_cpu_stalls=13.
  -> force both counters to 16'hFFFE, run 3 more DMA cycles -> both read 16'hFFFF.
